mem_port_arbiter: RTL

- Shares the single word-wide data memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- LS traffic arrives already formatted: word address, shifted write data, byte write mask.
- The block grants one requester at a time, drives the memory port, waits the fixed memory read latency, then returns read data or a write acknowledge to the granted requester.
- It sits between the fetch stage / load-store formatter and the memory.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the data memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_wmask;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;

   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_en, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_en, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data memory port: LS has priority, but IF
// is forced through after MAX_LS_STREAK consecutive LS grants while IF waits.
module mem_port_arbiter #(
   parameter int MEM_LATENCY   = 1,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   localparam int STK_W = $clog2(MAX_LS_STREAK + 1);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_LS_STREAK);
   localparam logic [2:0]       LAT     = 3'(MEM_LATENCY);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_cnt, w_cnt_nxt;
   logic [STK_W-1:0] r_streak, w_streak_nxt;
   logic             r_owner_ls;
   logic             r_we;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_if_rdata;
   logic [31:0]      r_ls_rdata;

   logic             w_gnt_if, w_gnt_ls, w_gnt_any, w_fire;
   logic             w_if_fire, w_ls_fire, w_store_gnt;
   logic [31:0]      w_addr, w_ls_rdata;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_streak_nxt = r_streak;
      w_gnt_if     = 1'b0;
      w_gnt_ls     = 1'b0;
      w_fire       = 1'b0;
      if (!reset) begin
         case (r_state)
            S_IDLE: begin
               if (bus.ls_req && (!bus.if_req || r_streak != STK_MAX))
                  w_gnt_ls = 1'b1;
               else if (bus.if_req)
                  w_gnt_if = 1'b1;
               if (w_gnt_if || w_gnt_ls) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = LAT;
               end
               // An LS grant with IF waiting can only happen below the cap, so +1 never overshoots.
               if (w_gnt_ls)
                  w_streak_nxt = bus.if_req ? r_streak + 1'b1 : '0;
               else if (w_gnt_if)
                  w_streak_nxt = '0;
            end
            S_WAIT: begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt == 3'd1) begin
                  w_fire      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_gnt_any   = w_gnt_if | w_gnt_ls;
   assign w_store_gnt = w_gnt_ls & bus.ls_we;
   assign w_addr      = w_gnt_ls ? (bus.ls_addr & 32'hFFFF_FFFC)
                                 : (bus.if_addr & 32'hFFFF_FFFC);
   assign w_if_fire   = w_fire & ~r_owner_ls;
   assign w_ls_fire   = w_fire &  r_owner_ls;
   assign w_ls_rdata  = r_we ? 32'h0 : bus.mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_streak   <= '0;
         r_owner_ls <= 1'b0;
         r_we       <= 1'b0;
         r_mem_addr <= 32'h0;
         r_if_rdata <= 32'h0;
         r_ls_rdata <= 32'h0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_streak <= w_streak_nxt;
         if (w_gnt_any) begin
            r_owner_ls <= w_gnt_ls;
            r_we       <= w_store_gnt;
            r_mem_addr <= w_addr;
         end
         if (w_if_fire) r_if_rdata <= bus.mem_rdata;
         if (w_ls_fire) r_ls_rdata <= w_ls_rdata;
      end
   end

   assign bus.if_gnt    = w_gnt_if;
   assign bus.ls_gnt    = w_gnt_ls;
   assign bus.if_rvalid = w_if_fire;
   assign bus.ls_rvalid = w_ls_fire;
   // Read data is visible in the pulse cycle itself, then held from the register.
   assign bus.if_rdata  = w_if_fire ? bus.mem_rdata : r_if_rdata;
   assign bus.ls_rdata  = w_ls_fire ? w_ls_rdata : r_ls_rdata;
   assign bus.mem_en    = w_gnt_any;
   assign bus.mem_addr  = w_gnt_any ? w_addr : r_mem_addr;
   assign bus.mem_wdata = w_store_gnt ? bus.ls_wdata : 32'h0;
   assign bus.mem_wmask = w_store_gnt ? bus.ls_wmask : 4'h0;
   assign bus.busy      = (r_state == S_WAIT) && !reset;

endmodule
